// File: rtl/game_cmd_queue_if.sv
// Producer-side command handshake for game_cmd_queue.
// WIDTH must match the WIDTH of the queue it connects to.
interface game_cmd_queue_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic             in_ready;
    logic             in_init;
    logic [1:0]       in_ctrl;
    logic [WIDTH-1:0] in_val;

    modport master (
        output in_valid,
        output in_init,
        output in_ctrl,
        output in_val,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_init,
        input  in_ctrl,
        input  in_val,
        output in_ready
    );
endinterface

// File: rtl/game_cmd_queue.sv
// Command FIFO feeding a game counter block; issues one command per cycle unless
// empty or GAMEOVER, otherwise drives a hold (reload current value) command.
module game_cmd_queue #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    game_cmd_queue_if.slave          cmd,
    input  logic                     GAMEOVER,
    output logic [1:0]               CTRL,
    output logic                     INIT,
    output logic [WIDTH-1:0]         val,
    output logic [WIDTH-1:0]         shadow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               issued
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        UP_1   = 2'd0,
        UP_2   = 2'd1,
        DOWN_1 = 2'd2,
        DOWN_2 = 2'd3
    } step_e;

    typedef struct packed {
        logic             init;
        step_e            ctrl;
        logic [WIDTH-1:0] val;
    } cmd_t;

    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] next_shadow;

    assign cmd.in_ready = (count != LVL_W'(DEPTH));
    assign level        = count;
    assign push         = cmd.in_valid && cmd.in_ready;
    assign pop          = (count != '0) && !GAMEOVER;
    assign head         = mem[rd_ptr];

    // NOTE: default assigned first so every path drives next_shadow and no latch is inferred.
    always_comb begin
        next_shadow = shadow;
        case (head.ctrl)
            UP_1:    next_shadow = shadow + WIDTH'(1);
            UP_2:    next_shadow = shadow + WIDTH'(2);
            DOWN_1:  next_shadow = shadow - WIDTH'(1);
            DOWN_2:  next_shadow = shadow - WIDTH'(2);
            default: next_shadow = shadow;
        endcase
    end

    // NOTE: storage has no reset; emptiness is tracked by count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{init: cmd.in_init, ctrl: step_e'(cmd.in_ctrl), val: cmd.in_val};
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            CTRL   <= 2'd0;
            INIT   <= 1'b1;
            val    <= '0;
            shadow <= '0;
            issued <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase

            if (pop) begin
                INIT   <= head.init;
                CTRL   <= head.ctrl;
                val    <= head.val;
                shadow <= head.init ? head.val : next_shadow;
                issued <= issued + 8'd1;
            end else begin
                // Hold: reload the counter with its own modelled value.
                INIT <= 1'b1;
                CTRL <= UP_1;
                val  <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_game_cmd_queue.sv
// Randomized scoreboard bench for game_cmd_queue: a queue-based model predicts each
// issued command; a negedge monitor compares issues, holds, level and ready.
module tb_game_cmd_queue;

    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam int MOD   = 1 << W;

    typedef struct {
        logic         init;
        logic [1:0]   ctrl;
        logic [W-1:0] val;
    } cmd_t;

    typedef struct {
        logic         init;
        logic [1:0]   ctrl;
        logic [W-1:0] val;
        int           shadow;
        int           issued;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic gameover;

    logic [1:0]   game_ctrl;
    logic         game_init;
    logic [W-1:0] game_val;
    logic [W-1:0] shadow;
    logic [2:0]   level;
    logic [7:0]   issued;

    game_cmd_queue_if #(.WIDTH(W)) bus ();

    game_cmd_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (bus),
        .GAMEOVER (gameover),
        .CTRL     (game_ctrl),
        .INIT     (game_init),
        .val      (game_val),
        .shadow   (shadow),
        .level    (level),
        .issued   (issued)
    );

    always #5 clk = ~clk;

    // Reference model state (written only by the model process).
    cmd_t m_q[$];
    exp_t exp_q[$];
    int   m_shadow = 0;
    int   m_issued = 0;

    // Bench bookkeeping.
    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input bit v, input bit i, input logic [1:0] c,
                         input logic [W-1:0] d, input bit g);
        bus.in_valid = v;
        bus.in_init  = i;
        bus.in_ctrl  = c;
        bus.in_val   = d;
        gameover     = g;
        @(posedge clk);
        #2;
    endtask

    // Model: at each edge issue the head (if any, and not game over), then accept a push.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_shadow = 0;
                m_issued = 0;
            end else begin
                int   pre;
                int   d;
                cmd_t h;
                cmd_t c;
                exp_t e;
                pre = m_q.size();
                if (pre != 0 && !gameover) begin
                    h = m_q.pop_front();
                    case (h.ctrl)
                        2'd0:    d = 1;
                        2'd1:    d = 2;
                        2'd2:    d = -1;
                        default: d = -2;
                    endcase
                    if (h.init) m_shadow = int'(h.val);
                    else        m_shadow = ((m_shadow + d) % MOD + MOD) % MOD;
                    m_issued = (m_issued + 1) % 256;
                    e.init   = h.init;
                    e.ctrl   = h.ctrl;
                    e.val    = h.val;
                    e.shadow = m_shadow;
                    e.issued = m_issued;
                    exp_q.push_back(e);
                end
                if (bus.in_valid && pre != DEPTH) begin
                    c.init = bus.in_init;
                    c.ctrl = bus.in_ctrl;
                    c.val  = bus.in_val;
                    m_q.push_back(c);
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT issues, otherwise checks the hold command.
    initial begin
        int   rd_idx;
        int   last_issued;
        exp_t e;
        rd_idx      = 0;
        last_issued = 0;
        while (!done) begin
            @(negedge clk);
            if (rst) begin
                check("rst_init",   int'(game_init), 1);
                check("rst_ctrl",   int'(game_ctrl), 0);
                check("rst_val",    int'(game_val),  0);
                check("rst_shadow", int'(shadow),    0);
                check("rst_level",  int'(level),     0);
                check("rst_ready",  int'(bus.in_ready), 1);
                check("rst_issued", int'(issued),    0);
                rd_idx      = exp_q.size();
                last_issued = 0;
            end else begin
                if (int'(issued) != last_issued) begin
                    if (rd_idx < exp_q.size()) begin
                        e = exp_q[rd_idx];
                        rd_idx++;
                        check("issue_init",   int'(game_init), int'(e.init));
                        check("issue_ctrl",   int'(game_ctrl), int'(e.ctrl));
                        check("issue_val",    int'(game_val),  int'(e.val));
                        check("issue_shadow", int'(shadow),    e.shadow);
                        check("issue_count",  int'(issued),    e.issued);
                    end else begin
                        check("unexpected_issue", int'(issued), last_issued);
                    end
                    last_issued = int'(issued);
                end else begin
                    check("hold_init",   int'(game_init), 1);
                    check("hold_ctrl",   int'(game_ctrl), 0);
                    check("hold_val",    int'(game_val),  m_shadow);
                    check("hold_shadow", int'(shadow),    m_shadow);
                end
                check("level", int'(level), m_q.size());
                check("ready", int'(bus.in_ready), int'(m_q.size() != DEPTH));
                check("issued_total", int'(issued), m_issued);
            end
        end
        check("unissued_expectations", rd_idx, exp_q.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Stimulus.
    initial begin
        bit go;
        rst          = 1'b1;
        gameover     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_init  = 1'b0;
        bus.in_ctrl  = 2'd0;
        bus.in_val   = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Idle after reset.
        repeat (3) drive(0, 0, 2'd0, 2'd0, 0);

        // Load 1, UP_2, DOWN_1 back to back -> shadow 1,3,2 then hold at 2.
        drive(1, 1, 2'd0, 2'd1, 0);
        drive(1, 0, 2'd1, 2'd0, 0);
        drive(1, 0, 2'd2, 2'd0, 0);
        repeat (3) drive(0, 0, 2'd0, 2'd0, 0);

        // Shadow wrap: 0 DOWN_2 -> 2; 3 UP_1 -> 0.
        drive(1, 1, 2'd0, 2'd0, 0);
        drive(1, 0, 2'd3, 2'd0, 0);
        drive(1, 1, 2'd0, 2'd3, 0);
        drive(1, 0, 2'd0, 2'd0, 0);
        repeat (3) drive(0, 0, 2'd0, 2'd0, 0);

        // Five pushes under GAMEOVER: fifth is held off by a full queue.
        for (int i = 0; i < 5; i++) drive(1, 0, 2'(i), 2'(i), 1);
        // Release with a full queue while pushing every cycle.
        for (int i = 0; i < 6; i++) drive(1, 0, 2'($urandom), 2'($urandom), 0);
        repeat (6) drive(0, 0, 2'd0, 2'd0, 0);

        // Reset with three commands queued; nothing stale may issue afterwards.
        for (int i = 0; i < 3; i++) drive(1, 0, 2'(i + 1), 2'(i), 1);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst      = 1'b0;
        gameover = 1'b0;
        repeat (3) drive(0, 0, 2'd0, 2'd0, 0);

        // Random traffic with GAMEOVER bursts; long enough to wrap issued.
        go = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) go = ~go;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  2'($urandom), 2'($urandom), go);
        end
        repeat (10) drive(0, 0, 2'd0, 2'd0, 0);
        done = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
